// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory request/response bundle used by the fetch stage.
//   req    : fetch stage -> memory, request valid
//   addr   : fetch stage -> memory, word-aligned fetch address
//   gnt    : memory -> fetch stage, request accepted this cycle
//   rvalid : memory -> fetch stage, read data valid (never in the gnt cycle)
//   rdata  : memory -> fetch stage, instruction word
interface pc_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// PC register and instruction-fetch stage writing the IF/ID pipeline register.
// Keeps at most one instruction-memory request outstanding and handles
// hazard-unit stalls and branch/jump redirects.
//   clk       : clock, all state on the rising edge
//   reset     : synchronous active-high reset
//   next_addr : next-address mux output, loaded when redirect=1 (bits [1:0] ignored)
//   redirect  : taken branch/jump; load next_addr and flush IF/ID (beats stall)
//   stall     : hold PC and IF/ID
//   pc_addr   : PC+4 (combinational) back to the next-address mux
//   pc        : current fetch address
//   imem      : instruction-memory request/response bundle (master side)
//   if_pc     : IF/ID PC of the delivered instruction
//   if_instr  : IF/ID instruction word
//   if_valid  : IF/ID valid, 0 = bubble
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              next_addr,
  input  logic                     redirect,
  input  logic                     stall,
  output logic [31:0]              pc_addr,
  output logic [31:0]              pc,
  pc_fetch_stage_if.master         imem,
  output logic [31:0]              if_pc,
  output logic [31:0]              if_instr,
  output logic                     if_valid
);

  // StDrop: a response is still owed to us for a squashed PC and must be eaten.
  typedef enum logic [1:0] {StFetch, StWait, StHold, StDrop} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        if_valid_q, if_valid_d;
  logic        deliver;
  logic [31:0] deliver_data;
  logic        unused_next_addr;

  assign unused_next_addr = ^next_addr[1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_d        = buf_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    if_valid_d   = if_valid_q;
    deliver      = 1'b0;
    deliver_data = '0;

    if (redirect) begin
      pc_d       = {next_addr[31:2], 2'b00};
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
      buf_d      = '0;
      // Any request already granted but not yet answered must be drained.
      unique case (state_q)
        StFetch: state_d = imem.gnt ? StDrop : StFetch;
        StWait:  state_d = imem.rvalid ? StFetch : StDrop;
        StHold:  state_d = StFetch;
        StDrop:  state_d = StDrop;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem.gnt) state_d = StWait;
        end
        StWait: begin
          if (imem.rvalid) begin
            if (stall) begin
              buf_d   = imem.rdata;
              state_d = StHold;
            end else begin
              deliver      = 1'b1;
              deliver_data = imem.rdata;
              state_d      = StFetch;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            deliver      = 1'b1;
            deliver_data = buf_q;
            state_d      = StFetch;
          end
        end
        StDrop: begin
          if (imem.rvalid) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase

      if (deliver) begin
        if_pc_d    = pc_q;
        if_instr_d = deliver_data;
        if_valid_d = 1'b1;
        pc_d       = pc_q + 32'd4;
      end else if (!stall) begin
        if_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFetch;
      pc_q       <= {RESET_PC[31:2], 2'b00};
      buf_q      <= '0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem.req  = (state_q == StFetch) && !reset;
  assign imem.addr = pc_q;
  assign pc        = pc_q;
  assign pc_addr   = pc_q + 32'd4;
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;
  assign if_valid  = if_valid_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
module tb_pc_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] next_addr = '0;
  logic [31:0] pc_addr, pc, if_pc, if_instr;
  logic        if_valid;

  pc_fetch_stage_if imem ();

  pc_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .next_addr (next_addr),
    .redirect  (redirect),
    .stall     (stall),
    .pc_addr   (pc_addr),
    .pc        (pc),
    .imem      (imem),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_valid  (if_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: architectural view of the fetch stage.
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_ifpc = 32'h0;
  logic [31:0] m_instr = NOP;
  logic        m_valid = 1'b0;
  logic        m_await = 1'b0;   // a granted request is still unanswered
  logic        m_squash = 1'b0;  // that unanswered request belongs to a dead path
  logic        m_hold = 1'b0;    // an instruction is parked waiting for stall to drop
  logic [31:0] m_buf = 32'h0;

  // Memory model.
  logic        pend = 1'b0;
  int          pend_lat = 0;
  logic [31:0] pend_data = 32'h0;
  int          gnt_pct = 100;
  int          lat_min = 0;
  int          lat_max = 0;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] na);
    logic        g, rv, do_rd, req_exp, have;
    logic [31:0] rdat, d, addr_before;
    @(negedge clk);
    g = 1'b0;
    rv = 1'b0;
    rdat = '0;
    do_rd = rd;
    if (!r && pend && pend_lat == 0) begin
      rv = 1'b1;
      rdat = pend_data;
    end
    req_exp = !r && !m_await && !m_hold;
    if (req_exp && int'($urandom_range(99)) < gnt_pct) g = 1'b1;
    // A redirect while draining with the response arriving would strand the stage.
    if (m_await && m_squash && rv) do_rd = 1'b0;
    reset = r;
    stall = s;
    redirect = do_rd;
    next_addr = na;
    imem.gnt = g;
    imem.rvalid = rv;
    imem.rdata = rdat;
    #1;
    chk("pc", pc, m_pc);
    chk("pc_addr", pc_addr, m_pc + 32'd4);
    chk("imem_req", {31'b0, imem.req}, {31'b0, req_exp});
    if (req_exp) chk("imem_addr", imem.addr, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("if_pc", if_pc, m_ifpc);
      chk("if_instr", if_instr, m_instr);
    end

    addr_before = m_pc;
    if (r) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_await = 1'b0; m_squash = 1'b0; m_hold = 1'b0; m_buf = 32'h0;
    end else if (do_rd) begin
      if (!m_await && !m_hold && g) begin
        m_await = 1'b1;
        m_squash = 1'b1;
      end else if (m_await && !m_squash) begin
        if (rv) m_await = 1'b0;
        else m_squash = 1'b1;
      end
      m_hold = 1'b0;
      m_buf = 32'h0;
      m_pc = {na[31:2], 2'b00};
      m_valid = 1'b0;
      m_instr = NOP;
    end else begin
      have = 1'b0;
      d = '0;
      if (!m_await && !m_hold) begin
        if (g) begin
          m_await = 1'b1;
          m_squash = 1'b0;
        end
      end else if (m_await && rv) begin
        m_await = 1'b0;
        if (m_squash) m_squash = 1'b0;
        else if (s) begin
          m_hold = 1'b1;
          m_buf = rdat;
        end else begin
          have = 1'b1;
          d = rdat;
        end
      end else if (m_hold && !s) begin
        m_hold = 1'b0;
        have = 1'b1;
        d = m_buf;
      end
      if (have) begin
        m_ifpc = m_pc;
        m_instr = d;
        m_valid = 1'b1;
        m_pc = m_pc + 32'd4;
      end else if (!s) begin
        m_valid = 1'b0;
      end
    end

    if (r) begin
      pend = 1'b0;
    end else begin
      if (rv) pend = 1'b0;
      else if (pend) pend_lat--;
      if (g) begin
        pend = 1'b1;
        pend_lat = int'($urandom_range(lat_max, lat_min));
        pend_data = instr_at(addr_before);
      end
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 12; i++) begin
      if (!m_await && !m_hold) break;
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
    end
    if (m_await || m_hold) chk(name, 32'h0, 32'h1);
  endtask

  initial begin
    logic seen;
    imem.gnt = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata = '0;

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h13);
    chk("rst_ifpc", if_pc, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem.req}, 32'h0);

    // First fetch: gnt immediately, rvalid next cycle
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_req", {31'b0, imem.req}, 32'h1);
    chk("first_addr", imem.addr, 32'h0);
    settle();
    chk("wait_req", {31'b0, imem.req}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("d0_ifpc", if_pc, 32'h0);
    chk("d0_instr", if_instr, 32'h0050_0093);
    chk("d0_valid", {31'b0, if_valid}, 32'h1);
    chk("d0_pc", pc, 32'h4);
    chk("d0_pcaddr", pc_addr, 32'h8);

    // Stall for three cycles while the response for PC=4 arrives
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("st1_valid", {31'b0, if_valid}, 32'h1);
    chk("st1_ifpc", if_pc, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("st2_req", {31'b0, imem.req}, 32'h0);
    chk("st2_instr", if_instr, 32'h0050_0093);
    chk("st2_pc", pc, 32'h4);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    settle();
    chk("st3_req", {31'b0, imem.req}, 32'h0);
    chk("st3_valid", {31'b0, if_valid}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("st_rel_instr", if_instr, 32'h00A0_0113);
    chk("st_rel_ifpc", if_pc, 32'h4);
    chk("st_rel_pc", pc, 32'h8);

    // Sequential run: bubble between every delivery
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("seq_bubble0", {31'b0, if_valid}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("seq_ifpc8", if_pc, 32'h8);
    chk("seq_valid8", {31'b0, if_valid}, 32'h1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("seq_bubble1", {31'b0, if_valid}, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("seq_ifpcC", if_pc, 32'hC);

    // Redirect in WAIT with no rvalid, then discard the stale response
    lat_min = 1;
    lat_max = 1;
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h40);
    settle();
    chk("rd_valid", {31'b0, if_valid}, 32'h0);
    chk("rd_instr", if_instr, 32'h13);
    chk("rd_pc", pc, 32'h40);
    chk("rd_req", {31'b0, imem.req}, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0);
      if (imem.req) begin
        seen = 1'b1;
        chk("rd_refetch_addr", imem.addr, 32'h40);
        break;
      end
    end
    if (!seen) chk("rd_refetch_timeout", 32'h0, 32'h1);

    // Redirect with stall, unaligned target
    cycle(1'b0, 1'b1, 1'b1, 32'h81);
    settle();
    chk("rs_pc", pc, 32'h80);
    chk("rs_valid", {31'b0, if_valid}, 32'h0);
    lat_min = 0;
    lat_max = 0;
    drain("drain1_timeout");

    // Reset mid-WAIT at PC=0x1C
    gnt_pct = 0;
    cycle(1'b0, 1'b0, 1'b1, 32'h1C);
    gnt_pct = 100;
    lat_min = 1;
    lat_max = 1;
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("mid_pc", pc, 32'h1C);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    settle();
    chk("mr_pc", pc, 32'h0);
    chk("mr_valid", {31'b0, if_valid}, 32'h0);
    chk("mr_req", {31'b0, imem.req}, 32'h0);
    lat_min = 0;
    lat_max = 0;
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mr_req_rel", {31'b0, imem.req}, 32'h1);
    drain("drain2_timeout");

    // Wraparound at the top of the address space
    gnt_pct = 0;
    cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    gnt_pct = 100;
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    settle();
    chk("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_valid", {31'b0, if_valid}, 32'h1);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pcaddr", pc_addr, 32'h4);

    // Randomised traffic against the model
    gnt_pct = 60;
    lat_min = 0;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(199) == 0), ($urandom_range(3) == 0),
            ($urandom_range(9) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- PC register and instruction-fetch stage; sits directly downstream of the next-address mux (consumes its Addr output as NextAddr) and feeds it PCAddr = PC+4.
- Issues one outstanding instruction-memory request at a time (req/gnt, then rvalid) and writes the IF/ID pipeline register.
- Handles stalls from the hazard unit and flushes/redirects on taken branches and jumps (blt/bge/beq/bne/jal/jalr).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, IF_Instr value on reset/flush (addi x0,x0,0)

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
NextAddr  in  32  next-address mux output; used only when Redirect=1
Redirect  in  1  taken branch/jump this cycle; load NextAddr, flush IF/ID
Stall  in  1  hazard-unit stall; hold IF/ID and PC
PCAddr  out  32  combinational PC+4, to next-address mux
PC  out  32  current fetch address (registered)
IMemReq  out  1  instruction-memory request
IMemAddr  out  32  request address = PC
IMemGnt  in  1  request accepted this cycle (when IMemReq=1)
IMemRValid  in  1  read data valid; never in the same cycle as its gnt
IMemRData  in  32  instruction word
IF_PC  out  32  IF/ID: PC of delivered instruction
IF_Instr  out  32  IF/ID: instruction word
IF_Valid  out  1  IF/ID: 1 = real instruction, 0 = bubble

Behaviour:
- Reset (any state, including mid-request): PC=RESET_PC, state=FETCH, IF_PC=0, IF_Instr=NOP_INSTR, IF_Valid=0, buffer cleared. IMemReq forced 0 while Reset=1. The memory shares Reset, so no stale rvalid follows.
- PC[1:0] is always 0; NextAddr[1:0] is ignored. PCAddr = {PC[31:2],2'b00}+4, 32-bit wraparound (32'hFFFF_FFFC -> 0).
- States:
  - FETCH: IMemReq=1, IMemAddr=PC; gnt -> WAIT. IMemRValid ignored.
  - WAIT: IMemReq=0; on rvalid: Stall=0 -> deliver, go FETCH; Stall=1 -> latch IMemRData in buffer, go HOLD.
  - HOLD: IMemReq=0; when Stall=0 -> deliver buffer, go FETCH.
  - DROP: IMemReq=0; the outstanding response belongs to a squashed PC; on rvalid discard and go FETCH.
- Deliver: IF_PC<=PC, IF_Instr<=data, IF_Valid<=1, PC<=PC+4.
- No deliverable instruction and Stall=0: IF_Valid<=0 (bubble); IF_PC/IF_Instr may hold.
- Stall=1, no Redirect: IF/ID and PC hold in every state.
- Redirect=1 has top priority over Stall in every state:
  - PC<=NextAddr; IF_Valid<=0; IF_Instr<=NOP_INSTR; buffer cleared.
  - Next state:
    - FETCH and gnt same cycle -> DROP.
    - FETCH without gnt -> FETCH (new PC presented next cycle).
    - WAIT with rvalid same cycle -> FETCH (response discarded).
    - WAIT without rvalid -> DROP.
    - HOLD -> FETCH.
    - DROP -> DROP (PC updated again).
- Latency: with gnt in FETCH and rvalid one cycle later, the instruction appears on IF/ID 2 cycles after IMemReq first asserted. Peak throughput is 1 instruction per 2 cycles.
- At most one outstanding request; IMemReq never asserts outside FETCH.

Test Plan:
- Reset release, memory gnt immediate, rvalid +1 cycle, data 0x00500093 -> IMemAddr=0 in first FETCH; IF_PC=0, IF_Instr=0x00500093, IF_Valid=1 two cycles later; PC=4, PCAddr=8.
- Sequential run, 4 fetches -> IF_PC sequence 0,4,8,C; one IF_Valid=0 bubble between each delivery.
- Stall=1 held 3 cycles, rvalid arrives during stall with 0x00A00113 -> state HOLD, IF/ID unchanged, IMemReq=0; after Stall drops, IF_Instr=0x00A00113 next edge, PC advances by 4.
- Redirect=1, NextAddr=0x40 while in WAIT without rvalid -> IF_Valid=0, IF_Instr=0x13, DROP; next rvalid discarded; following request IMemAddr=0x40.
- Redirect with Stall=1 simultaneously, NextAddr=0x81 -> PC=0x80 (low bits ignored), IF_Valid=0 despite stall.
- Reset asserted mid-WAIT with PC=0x1C -> next cycle PC=0, IF_Valid=0, IMemReq=0 during reset, 1 after release. PC=0xFFFFFFFC delivery -> PC wraps to 0.
